// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and default constants for the FIFO write arbiter.
//   arb_state_t   : arbiter FSM states (IDLE, BURST)
//   *_DEF         : default NUM_REQ, DATA_W and BURST_MAX
//   idx_width()   : width of a requester index for a given requester count
package fifo_arb_pkg;

    localparam int unsigned NUM_REQ_DEF   = 4;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned BURST_MAX_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester/FIFO-side bundle of the FIFO write arbiter.
//   req, req_data, req_last : per-requester beat valid, data, last-beat flag
//   mem_full                : FIFO full flag
//   grant, ack              : one-hot owner and one-hot beat acceptance
//   write_en, data_in       : FIFO write port
//   busy, beat_total        : arbiter status and accepted-beat count
// Modports: master = requesters/FIFO side, slave = arbiter.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic                      mem_full;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        ack;
    logic                      write_en;
    logic [DATA_W-1:0]         data_in;
    logic                      busy;
    logic [15:0]               beat_total;

    modport master (
        output req, req_data, req_last, mem_full,
        input  grant, ack, write_en, data_in, busy, beat_total
    );

    modport slave (
        input  req, req_data, req_last, mem_full,
        output grant, ack, write_en, data_in, busy, beat_total
    );

endinterface

// File: rtl/fifo_arb_rr_pick.sv
// fifo_arb_rr_pick: winner selection for the FIFO write arbiter.
//   req         : per-requester request vector
//   last_winner : index of the previous burst owner
//   pick        : one-hot winner (all zero when req is zero)
// Build option FIFO_ARB_FIXED_PRIO_EN: lowest index wins and last_winner is
// ignored; otherwise round-robin starting at last_winner+1 modulo NUM_REQ.
module fifo_arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ = NUM_REQ_DEF,
    localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] pick
);

    logic found;

`ifdef FIFO_ARB_FIXED_PRIO_EN

    logic unused_last_winner;
    assign unused_last_winner = ^last_winner;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && req[IDX_W'(k)]) begin
                pick[IDX_W'(k)] = 1'b1;
                found           = 1'b1;
            end
        end
    end

`else

    int unsigned cand;

    // Offsets 1..NUM_REQ so the previous winner is visited last.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_winner) + k) % NUM_REQ;
            if (!found && req[IDX_W'(cand)]) begin
                pick[IDX_W'(cand)] = 1'b1;
                found              = 1'b1;
            end
        end
    end

`endif

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one FIFO write port between NUM_REQ requesters in
// bursts of up to BURST_MAX beats.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : fifo_wr_arbiter_if.slave (requests, FIFO write port, status)
// Build option FIFO_ARB_FIXED_PRIO_EN (in fifo_arb_rr_pick) selects fixed
// priority instead of round-robin winner selection.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
    input  logic            clk,
    input  logic            reset,
    fifo_wr_arbiter_if.slave bus
);

    localparam int unsigned IDX_W       = idx_width(NUM_REQ);
    localparam logic [3:0]  BURST_LIMIT = 4'(BURST_MAX);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   last_winner_q;
    logic [3:0]         beat_cnt_q;
    logic [15:0]        beat_total_q;
    logic               owner_req;
    logic               owner_last;
    logic               accept;
    logic               burst_end;

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req         (bus.req),
        .last_winner (last_winner_q),
        .pick        (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (pick[IDX_W'(k)]) begin
                pick_idx = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_req    = 1'b0;
        owner_last   = 1'b0;
        accept       = 1'b0;
        burst_end    = 1'b0;
        bus.write_en = 1'b0;
        bus.ack      = '0;
        bus.data_in  = '0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                owner_req    = bus.req[owner_q];
                owner_last   = bus.req_last[owner_q];
                accept       = owner_req & ~bus.mem_full;
                bus.write_en = accept;
                bus.ack      = accept ? grant_q : '0;
                bus.data_in  = bus.req_data[owner_q*DATA_W +: DATA_W];
                // A stalled last/limit beat is not accepted, so it cannot end the burst.
                burst_end    = !owner_req ||
                               (accept && (owner_last || (beat_cnt_q + 4'd1 == BURST_LIMIT)));
                if (burst_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q       <= '0;
            owner_q       <= '0;
            beat_cnt_q    <= '0;
            beat_total_q  <= '0;
            last_winner_q <= IDX_W'(NUM_REQ - 1);
        end else if (state_q == IDLE) begin
            if (|bus.req) begin
                grant_q    <= pick;
                owner_q    <= pick_idx;
                beat_cnt_q <= '0;
            end
        end else begin
            if (accept) begin
                beat_cnt_q   <= beat_cnt_q + 4'd1;
                beat_total_q <= beat_total_q + 16'd1;
            end
            if (burst_end) begin
                grant_q       <= '0;
                last_winner_q <= owner_q;
            end
        end
    end

    assign bus.grant      = grant_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.beat_total = beat_total_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios for fifo_wr_arbiter with a beat
// scoreboard (expected owner/data pushed per planned burst, popped on each
// FIFO write). Honours FIFO_ARB_FIXED_PRIO_EN for the priority scenario.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned BM = 4;

    typedef struct {
        int unsigned idx;
        logic [7:0]  data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .BURST_MAX (BM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        sb[$];
    int unsigned tb_beats[NR];
    int unsigned plan_beats[NR];
    int          total = 0;
    int          bad   = 0;
    int unsigned g_a, g_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Each requester sends data idx*64 + its running beat number.
    task automatic push_burst(input int unsigned idx, input int unsigned n);
        exp_t e;
        for (int unsigned k = 0; k < n; k++) begin
            e.idx  = idx;
            e.data = 8'(idx * 64 + plan_beats[idx]);
            plan_beats[idx]++;
            sb.push_back(e);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic f);
        exp_t e;
        @(negedge clk);
        bus.req      = r;
        bus.req_last = l;
        bus.mem_full = f;
        for (int unsigned i = 0; i < NR; i++) begin
            bus.req_data[i*DW +: DW] = 8'(i * 64 + tb_beats[i]);
        end
        #1;
        if (bus.write_en) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_underflow got=write exp=no_write");
            end else begin
                e = sb.pop_front();
                chk("sb_ack", 32'(bus.ack), 32'(1) << e.idx);
                chk("sb_data", 32'(bus.data_in), 32'(e.data));
            end
        end
        for (int unsigned i = 0; i < NR; i++) begin
            if (bus.ack[i]) tb_beats[i]++;
        end
    endtask

    initial begin
        bus.req      = '0;
        bus.req_last = '0;
        bus.mem_full = 1'b0;
        bus.req_data = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            tb_beats[i]   = 0;
            plan_beats[i] = 0;
        end

        // Reset state
        #1;
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_total", 32'(bus.beat_total), 32'h0);
        chk("rst_wen", 32'(bus.write_en), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // All requesting: grants 0,1,2,3,0, four beats each, one idle cycle between
        for (int unsigned b = 0; b < 5; b++) push_burst(b % 4, 4);
        for (int unsigned c = 0; c <= 24; c++) begin
            step(4'hF, 4'h0, 1'b0);
            if (c == 0) begin
                chk("rr_idle0", 32'(bus.busy), 32'h0);
            end else if ((c - 1) % 5 < 4) begin
                chk("rr_grant", 32'(bus.grant), 32'(1) << (((c - 1) / 5) % 4));
                chk("rr_wen", 32'(bus.write_en), 32'h1);
            end else begin
                chk("rr_gap_grant", 32'(bus.grant), 32'h0);
                chk("rr_gap_busy", 32'(bus.busy), 32'h0);
                chk("rr_gap_wen", 32'(bus.write_en), 32'h0);
            end
            if (c == 20) chk("rr_total16", 32'(bus.beat_total), 32'd16);
        end
        step(4'h0, 4'h0, 1'b0);
        chk("rr_end_busy", 32'(bus.busy), 32'h0);
        chk("sb_drain1", sb.size(), 32'h0);

        // Requester 2 alone, last on the 2nd beat
        push_burst(2, 2);
        step(4'h4, 4'h0, 1'b0);
        chk("last_idle", 32'(bus.busy), 32'h0);
        step(4'h4, 4'h0, 1'b0);
        chk("last_grant", 32'(bus.grant), 32'h4);
        step(4'h4, 4'h4, 1'b0);
        chk("last_wen", 32'(bus.write_en), 32'h1);
        step(4'h0, 4'h0, 1'b0);
        chk("last_busy_fall", 32'(bus.busy), 32'h0);
        chk("last_total", 32'(bus.beat_total), 32'd22);

        // Three stalled cycles mid-burst on requester 1
        push_burst(1, 4);
        step(4'h2, 4'h0, 1'b0);
        step(4'h2, 4'h0, 1'b0);
        chk("stall_wen_pre", 32'(bus.write_en), 32'h1);
        for (int unsigned k = 0; k < 3; k++) begin
            step(4'h2, 4'h0, 1'b1);
            chk("stall_wen", 32'(bus.write_en), 32'h0);
            chk("stall_grant", 32'(bus.grant), 32'h2);
            chk("stall_total", 32'(bus.beat_total), 32'd23);
        end
        for (int unsigned k = 0; k < 3; k++) begin
            step(4'h2, 4'h0, 1'b0);
            chk("stall_resume", 32'(bus.write_en), 32'h1);
        end
        step(4'h0, 4'h0, 1'b0);
        chk("stall_busy", 32'(bus.busy), 32'h0);
        chk("stall_total_end", 32'(bus.beat_total), 32'd26);

        // Last beat while full is not accepted and does not end the burst
        push_burst(0, 1);
        step(4'h1, 4'h0, 1'b0);
        step(4'h1, 4'h1, 1'b1);
        chk("fulllast_wen", 32'(bus.write_en), 32'h0);
        step(4'h1, 4'h1, 1'b0);
        chk("fulllast_busy", 32'(bus.busy), 32'h1);
        chk("fulllast_wen2", 32'(bus.write_en), 32'h1);
        step(4'h0, 4'h0, 1'b0);
        chk("fulllast_done", 32'(bus.busy), 32'h0);
        chk("fulllast_total", 32'(bus.beat_total), 32'd27);

        // Reset during beat 2 of requester 1
        push_burst(1, 2);
        step(4'h2, 4'h0, 1'b0);
        step(4'h2, 4'h0, 1'b0);
        step(4'h2, 4'h0, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(bus.grant), 32'h0);
        chk("mid_rst_total", 32'(bus.beat_total), 32'h0);
        chk("mid_rst_wen", 32'(bus.write_en), 32'h0);
        @(posedge clk);
        #2;
        reset   = 1'b0;
        bus.req = '0;
        push_burst(0, 1);
        step(4'h3, 4'h0, 1'b0);
        chk("post_rst_idle", 32'(bus.busy), 32'h0);
        step(4'h3, 4'h0, 1'b0);
        chk("post_rst_grant", 32'(bus.grant), 32'h1);
        step(4'h0, 4'h0, 1'b0);
        chk("reqdrop_wen", 32'(bus.write_en), 32'h0);
        step(4'h0, 4'h0, 1'b0);
        chk("reqdrop_busy", 32'(bus.busy), 32'h0);
        chk("post_rst_total", 32'(bus.beat_total), 32'd1);

        // beat_total wrap
        #1;
        dut.beat_total_q = 16'hFFFF;
        push_burst(2, 1);
        step(4'h4, 4'h0, 1'b0);
        chk("wrap_pre", 32'(bus.beat_total), 32'hFFFF);
        step(4'h4, 4'h4, 1'b0);
        step(4'h0, 4'h0, 1'b0);
        chk("wrap_zero", 32'(bus.beat_total), 32'h0);

        // req=1010 held: round-robin alternates, fixed priority stays on 1
`ifdef FIFO_ARB_FIXED_PRIO_EN
        g_a = 1;
        g_b = 1;
`else
        g_a = 3;
        g_b = 1;
`endif
        push_burst(g_a, 4);
        push_burst(g_b, 4);
        for (int unsigned c = 0; c <= 9; c++) begin
            step(4'hA, 4'h0, 1'b0);
            if (c >= 1 && c <= 4) chk("prio_grant_a", 32'(bus.grant), 32'(1) << g_a);
            if (c == 5) chk("prio_gap", 32'(bus.busy), 32'h0);
            if (c >= 6) chk("prio_grant_b", 32'(bus.grant), 32'(1) << g_b);
        end
        step(4'h0, 4'h0, 1'b0);
        chk("prio_end", 32'(bus.busy), 32'h0);
        chk("sb_drain_end", sb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
